// File: rtl/axis_width_downsizer_if.sv
// AXI4-Stream bundle shared by the wide and narrow sides
// of the width downsizer.
interface axis_width_downsizer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast,
    output tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast,
    input  tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_width_downsizer.sv
// Wide-to-narrow AXI4-Stream serialiser: one input beat becomes
// SEG_COUNT output segments, LSB segment first, trailing empties cut.
module axis_width_downsizer #(
  parameter int S_DATA_WIDTH  = 64,
  parameter int S_KEEP_WIDTH  = S_DATA_WIDTH / 8,
  parameter int M_DATA_WIDTH  = 8,
  parameter bit M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
  parameter int M_KEEP_WIDTH  = M_DATA_WIDTH / 8,
  parameter bit ID_ENABLE     = 1'b0,
  parameter int ID_WIDTH      = 8,
  parameter bit DEST_ENABLE   = 1'b0,
  parameter int DEST_WIDTH    = 8,
  parameter bit USER_ENABLE   = 1'b1,
  parameter int USER_WIDTH    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_width_downsizer_if.slave  s_axis,
  axis_width_downsizer_if.master m_axis
);

  localparam int MKW = M_KEEP_ENABLE ? M_KEEP_WIDTH : 1;
  localparam int SEG_COUNT = S_KEEP_WIDTH / MKW;
  localparam int CNT_W = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;

  if (S_DATA_WIDTH / S_KEEP_WIDTH != M_DATA_WIDTH / MKW) begin : g_bad_lane
    $error("axis_width_downsizer: byte lane width mismatch");
  end
  if ((S_KEEP_WIDTH % MKW != 0) || (S_KEEP_WIDTH <= MKW)) begin : g_bad_ratio
    $error("axis_width_downsizer: keep ratio must be an integer > 1");
  end

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  state_t                  state_q, state_d;
  logic [S_DATA_WIDTH-1:0] data_q, data_d;
  logic [S_KEEP_WIDTH-1:0] keep_q, keep_d;
  logic                    last_q, last_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [CNT_W-1:0]        seg_q, seg_d;
  logic [CNT_W-1:0]        lseg_q, lseg_d;

  logic [CNT_W-1:0] in_lseg;
  logic             seg_done;
  logic             s_ready;
  logic             accept;
  logic             m_hs;

  // Final beat: stop at the highest segment carrying any keep bit.
  always_comb begin
    in_lseg = CNT_W'(SEG_COUNT - 1);
    if (s_axis.tlast) begin
      in_lseg = '0;
      for (int i = 0; i < SEG_COUNT; i++) begin
        if (|s_axis.tkeep[i*MKW +: MKW]) begin
          in_lseg = CNT_W'(i);
        end
      end
    end
  end

  assign seg_done = (seg_q == lseg_q);
  assign s_ready  = (state_q == IDLE) ||
                    (m_axis.tready && seg_done);
  assign accept   = s_axis.tvalid && s_ready;
  assign m_hs     = (state_q == XFER) && m_axis.tready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    id_d    = id_q;
    dest_d  = dest_q;
    user_d  = user_q;
    seg_d   = seg_q;
    lseg_d  = lseg_q;
    if (accept) begin
      state_d = XFER;
      data_d  = s_axis.tdata;
      keep_d  = s_axis.tkeep;
      last_d  = s_axis.tlast;
      id_d    = ID_ENABLE ? s_axis.tid : '0;
      dest_d  = DEST_ENABLE ? s_axis.tdest : '0;
      user_d  = USER_ENABLE ? s_axis.tuser : '0;
      seg_d   = '0;
      lseg_d  = in_lseg;
    end else if (m_hs) begin
      if (seg_done) begin
        state_d = IDLE;
      end else begin
        seg_d = seg_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
      seg_q   <= '0;
      lseg_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      id_q    <= id_d;
      dest_q  <= dest_d;
      user_q  <= user_d;
      seg_q   <= seg_d;
      lseg_q  <= lseg_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = (state_q == XFER);
  assign m_axis.tlast  = (state_q == XFER) && last_q && seg_done;
  assign m_axis.tdata  =
    data_q[int'(seg_q)*M_DATA_WIDTH +: M_DATA_WIDTH];
  assign m_axis.tid    = id_q;
  assign m_axis.tdest  = dest_q;
  assign m_axis.tuser  = user_q;

  if (M_KEEP_ENABLE) begin : g_keep
    assign m_axis.tkeep = keep_q[int'(seg_q)*MKW +: MKW];
  end else begin : g_no_keep
    assign m_axis.tkeep = M_KEEP_WIDTH'(1);
  end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Scoreboard bench for the 64->8 downsizer with a
// frame-level reference model and random backpressure.
module tb_axis_width_downsizer;

  localparam int SEG = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_width_downsizer_if #(
    .DATA_WIDTH(64), .KEEP_WIDTH(8),
    .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)
  ) s_if ();
  axis_width_downsizer_if #(
    .DATA_WIDTH(8), .KEEP_WIDTH(1),
    .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)
  ) m_if ();

  axis_width_downsizer #(
    .S_DATA_WIDTH(64), .S_KEEP_WIDTH(8),
    .M_DATA_WIDTH(8), .M_KEEP_ENABLE(1'b1),
    .M_KEEP_WIDTH(1),
    .ID_ENABLE(1'b1), .ID_WIDTH(8),
    .DEST_ENABLE(1'b1), .DEST_WIDTH(8),
    .USER_ENABLE(1'b1), .USER_WIDTH(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  typedef struct {
    logic [7:0] d;
    logic       k;
    logic       l;
    logic [7:0] id;
    logic [7:0] dest;
    logic       u;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_tlast_cyc = 0;
  int acc_cyc = 0;
  bit rmode_rand = 1'b0;

  bit         held = 1'b0;
  logic [7:0] h_d;
  logic       h_k, h_l;
  logic [7:0] h_id;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A frame-level view: a beat yields 8 bytes, the final beat is
  // cut after its highest kept byte, but always yields one segment.
  function automatic void model(logic [63:0] d, logic [7:0] k,
                                logic l, logic [7:0] id,
                                logic [7:0] dest, logic u);
    int n;
    exp_t x;
    n = SEG;
    if (l) begin
      n = 1;
      for (int i = 0; i < SEG; i++) if (k[i]) n = i + 1;
    end
    for (int i = 0; i < n; i++) begin
      x.d = d[8*i +: 8];
      x.k = k[i];
      x.l = l && (i == n - 1);
      x.id = id;
      x.dest = dest;
      x.u = u;
      sb.push_back(x);
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rmode_rand) m_if.tready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst && m_if.tvalid) begin
      if (held) begin
        chk("hold_data", m_if.tdata, h_d);
        chk("hold_keep", m_if.tkeep, h_k);
        chk("hold_last", m_if.tlast, h_l);
        chk("hold_id", m_if.tid, h_id);
      end
      if (m_if.tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("data", m_if.tdata, e.d);
          chk("keep", m_if.tkeep, e.k);
          chk("last", m_if.tlast, e.l);
          chk("id", m_if.tid, e.id);
          chk("dest", m_if.tdest, e.dest);
          chk("user", m_if.tuser, e.u);
        end
        if (m_if.tlast) begin
          chk("s_ready_on_last", s_if.tready, 1);
          last_tlast_cyc = cyc;
        end
        hs_cnt++;
      end
      held = !m_if.tready;
      h_d = m_if.tdata;
      h_k = m_if.tkeep[0];
      h_l = m_if.tlast;
      h_id = m_if.tid;
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(logic [63:0] d, logic [7:0] k, logic l,
                      logic [7:0] id, logic [7:0] dest, logic u);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    s_if.tdata = d;
    s_if.tkeep = k;
    s_if.tlast = l;
    s_if.tid = id;
    s_if.tdest = dest;
    s_if.tuser = u;
    s_if.tvalid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (s_if.tready) ok = 1'b1;
      t++;
    end
    if (ok) begin
      model(d, k, l, id, dest, u);
      acc_cyc = cyc;
    end else begin
      chk("accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a, hs0, gap;
    logic [63:0] d;
    logic [7:0] k;
    logic l;

    s_if.tdata = '0;
    s_if.tkeep = '0;
    s_if.tlast = 1'b0;
    s_if.tid = '0;
    s_if.tdest = '0;
    s_if.tuser = '0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_if.tvalid, 0);
    chk("rst_s_ready", s_if.tready, 1);
    chk("rst_data", m_if.tdata, 0);
    chk("rst_keep", m_if.tkeep, 0);
    chk("rst_last", m_if.tlast, 0);
    chk("rst_id", m_if.tid, 0);
    chk("rst_dest", m_if.tdest, 0);
    chk("rst_user", m_if.tuser, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(64'h0807060504030201, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
    a = acc_cyc;
    drain();
    chk("full_beat_span", last_tlast_cyc - a, 8);

    send(64'h123456789ACCBBAA, 8'h07, 1'b1, 8'h01, 8'h02, 1'b0);
    a = acc_cyc;
    drain();
    chk("partial_beat_span", last_tlast_cyc - a, 3);

    hs0 = hs_cnt;
    send(64'hF7E6D5C4B3A29180, 8'hFF, 1'b0, 8'h10, 8'h20, 1'b1);
    a = acc_cyc;
    send(64'h0F1E2D3C4B5A6978, 8'hFF, 1'b1, 8'h10, 8'h20, 1'b1);
    drain();
    chk("b2b_span", last_tlast_cyc - a, 16);
    chk("b2b_count", hs_cnt - hs0, 16);

    send(64'h8877665544332211, 8'hFF, 1'b1, 8'h33, 8'h44, 1'b0);
    @(posedge clk); #1; m_if.tready = 1'b0;
    @(posedge clk); #1; m_if.tready = 1'b0;
    @(posedge clk); #1; m_if.tready = 1'b1;
    drain();

    send(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1, 8'h55, 8'h66, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_m_valid", m_if.tvalid, 0);
    chk("midrst_s_ready", s_if.tready, 1);
    chk("midrst_last", m_if.tlast, 0);
    @(posedge clk);
    #1;
    send(64'h1111111111111111, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
    drain();

    send(64'h0123456789ABCDEF, 8'h00, 1'b1, 8'h5A, 8'h03, 1'b1);
    a = acc_cyc;
    drain();
    chk("empty_beat_span", last_tlast_cyc - a, 1);

    rmode_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      d = {$urandom, $urandom};
      l = ($urandom_range(0, 3) == 0);
      k = 8'($urandom);
      if (l && $urandom_range(0, 7) == 0) k = 8'h00;
      send(d, k, l, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    drain();
    rmode_rand = 1'b0;
    m_if.tready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
